// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and limits for the round-robin key arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

   localparam int N_REQ_MAX = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_key_arbiter_if.sv
// ============================================================================
// Module      : rr_key_arbiter_if
// Description : Requester and downstream signal bundle for rr_key_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_key_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int KEY_W = 4,
   parameter int ID_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*KEY_W-1:0] req_key;
   logic [N_REQ-1:0]       ack;
   logic                   down_valid;
   logic [KEY_W-1:0]       down_key;
   logic [ID_W-1:0]        down_id;
   logic                   down_ready;
   logic                   down_done;
   logic                   busy;

   // Arbiter side
   modport slave (
      input  req, req_key, down_ready, down_done,
      output ack, down_valid, down_key, down_id, busy
   );

   // Requesters plus downstream resource side
   modport master (
      output req, req_key, down_ready, down_done,
      input  ack, down_valid, down_key, down_id, busy
   );
endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin winner select (rotate/encode/unrotate).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  wire logic [N_REQ-1:0] req_i,
   input  wire logic [ID_W-1:0]  rr_ptr_i,
   output logic                  any_req_o,
   output logic [ID_W-1:0]       winner_o
);
   localparam int SW = ID_W + 1;

   logic [N_REQ-1:0] w_rot;
   logic [ID_W-1:0]  w_off;
   logic             w_found;
   logic [SW-1:0]    w_sum;

   always_comb begin
      w_rot     = '0;
      w_off     = '0;
      w_found   = 1'b0;
      w_sum     = '0;
      any_req_o = |req_i;

      // Rotated bit i is the request at (rr_ptr + i) mod N_REQ
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, rr_ptr_i} + SW'(i);
         if (w_sum >= SW'(N_REQ)) begin
            w_sum = w_sum - SW'(N_REQ);
         end
         w_rot[i] = req_i[w_sum[ID_W-1:0]];
      end

      for (int i = 0; i < N_REQ; i++) begin
         if (!w_found && w_rot[i]) begin
            w_found = 1'b1;
            w_off   = ID_W'(i);
         end
      end

      w_sum = {1'b0, rr_ptr_i} + {1'b0, w_off};
      if (w_sum >= SW'(N_REQ)) begin
         w_sum = w_sum - SW'(N_REQ);
      end
      winner_o = w_sum[ID_W-1:0];
   end

endmodule

`default_nettype wire

// File: rtl/rr_key_arbiter.sv
// ============================================================================
// Module      : rr_key_arbiter
// Description : Round-robin arbiter sharing one key-processing resource; all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_key_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int KEY_W = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  wire logic      clk,
   input  wire logic      rst,
   rr_key_arbiter_if.slave bus
);

   if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_param_check
      $error("rr_key_arbiter: N_REQ out of range");
   end

   state_t           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  down_id_q, down_id_d;
   logic [KEY_W-1:0] down_key_q, down_key_d;
   logic             down_valid_q, down_valid_d;
   logic [N_REQ-1:0] ack_q, ack_d;

   logic             w_any_req;
   logic [ID_W-1:0]  w_winner;
   logic [KEY_W-1:0] w_sel_key;
   logic [N_REQ-1:0] w_id_onehot;
   logic [ID_W-1:0]  w_ptr_next;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .req_i     (bus.req),
      .rr_ptr_i  (rr_ptr_q),
      .any_req_o (w_any_req),
      .winner_o  (w_winner)
   );

   always_comb begin
      w_sel_key   = '0;
      w_id_onehot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == w_winner) begin
            w_sel_key = bus.req_key[i*KEY_W +: KEY_W];
         end
         w_id_onehot[i] = (ID_W'(i) == down_id_q);
      end
   end

   assign w_ptr_next = (down_id_q == ID_W'(N_REQ - 1)) ? '0 : down_id_q + ID_W'(1);

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      down_id_d    = down_id_q;
      down_key_d   = down_key_q;
      down_valid_d = down_valid_q;
      ack_d        = '0;

      case (state_q)
         IDLE: begin
            if (w_any_req) begin
               down_id_d    = w_winner;
               down_key_d   = w_sel_key;
               down_valid_d = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            // down_done is deliberately ignored until the key is accepted
            if (down_valid_q && bus.down_ready) begin
               down_valid_d = 1'b0;
               state_d      = WAIT;
            end
         end
         WAIT: begin
            if (bus.down_done) begin
               ack_d   = w_id_onehot;
               state_d = ACK;
            end
         end
         ACK: begin
            rr_ptr_d = w_ptr_next;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         down_id_q    <= '0;
         down_key_q   <= '0;
         down_valid_q <= 1'b0;
         ack_q        <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         down_id_q    <= down_id_d;
         down_key_q   <= down_key_d;
         down_valid_q <= down_valid_d;
         ack_q        <= ack_d;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.down_valid = down_valid_q;
   assign bus.down_key   = down_key_q;
   assign bus.down_id    = down_id_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rr_key_arbiter.sv
// ============================================================================
// Module      : tb_rr_key_arbiter
// Description : Scoreboard bench for rr_key_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_key_arbiter;

   localparam int N  = 4;
   localparam int KW = 4;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [KW-1:0] key;
   } offer_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rr_key_arbiter_if #(.N_REQ(N), .KEY_W(KW), .ID_W(IW)) bus ();

   rr_key_arbiter #(.N_REQ(N), .KEY_W(KW), .ID_W(IW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int       n_checks = 0;
   int       n_fail   = 0;
   int       model_ptr = 0;
   offer_t   q_offer[$];
   int       q_ack[$];

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Grant rule: first requesting index scanning upward from the pointer
   function automatic int model_pick(input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(model_ptr + k) % N]) return (model_ptr + k) % N;
      end
      return -1;
   endfunction

   // Monitor: pops expectations whenever the DUT presents an offer or an ack
   initial begin
      logic   prev_valid;
      offer_t cur;
      offer_t e;
      int     id;
      prev_valid = 1'b0;
      cur        = '0;
      forever begin
         @(negedge clk);
         if (bus.down_valid && !prev_valid) begin
            check(q_offer.size() != 0, "offer_unexpected", 32'(bus.down_id), 32'hFFFF);
            if (q_offer.size() != 0) begin
               e   = q_offer.pop_front();
               cur = e;
               check(bus.down_id == e.id, "offer_id", 32'(bus.down_id), 32'(e.id));
               check(bus.down_key == e.key, "offer_key", 32'(bus.down_key), 32'(e.key));
            end
         end else if (bus.down_valid) begin
            check(bus.down_id == cur.id, "id_stable", 32'(bus.down_id), 32'(cur.id));
            check(bus.down_key == cur.key, "key_stable", 32'(bus.down_key), 32'(cur.key));
         end
         if (bus.ack != '0) begin
            check($onehot(bus.ack), "ack_onehot", 32'(bus.ack), 32'h1);
            check(q_ack.size() != 0, "ack_unexpected", 32'(bus.ack), 32'h0);
            if (q_ack.size() != 0) begin
               id = q_ack.pop_front();
               check(bus.ack == N'(1 << id), "ack_vector", 32'(bus.ack), 32'(1 << id));
            end
         end
         prev_valid = bus.down_valid;
      end
   end

   task automatic check_all_zero(input string tag);
      check(bus.ack == '0, {tag, "_ack"}, 32'(bus.ack), 32'h0);
      check(bus.down_valid == 1'b0, {tag, "_valid"}, 32'(bus.down_valid), 32'h0);
      check(bus.down_key == '0, {tag, "_key"}, 32'(bus.down_key), 32'h0);
      check(bus.down_id == '0, {tag, "_id"}, 32'(bus.down_id), 32'h0);
      check(bus.busy == 1'b0, {tag, "_busy"}, 32'(bus.busy), 32'h0);
   endtask

   task automatic run_txn(input logic [N-1:0] r, input logic [N*KW-1:0] keys,
                          input int rdly, input int ddly, input bit mutate,
                          input bit spur, input bit abort_rst);
      int            exp_id;
      logic [KW-1:0] exp_key;
      int            cnt;
      offer_t        o;
      cnt = 0;
      while (bus.busy && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check(!bus.busy, "idle_before_txn", 32'(bus.busy), 32'h0);
      bus.req     = r;
      bus.req_key = keys;
      exp_id      = model_pick(r);
      exp_key     = keys[exp_id*KW +: KW];
      o.id        = IW'(exp_id);
      o.key       = exp_key;
      q_offer.push_back(o);
      q_ack.push_back(exp_id);

      @(negedge clk);
      check(bus.down_valid == 1'b1, "grant_latency", 32'(bus.down_valid), 32'h1);
      check(bus.busy == 1'b1, "busy_on_grant", 32'(bus.busy), 32'h1);
      if (mutate) begin
         bus.req[exp_id]                = 1'b0;
         bus.req_key[exp_id*KW +: KW]   = ~exp_key;
      end
      if (spur) begin
         bus.down_done = 1'b1;
         @(negedge clk);
         bus.down_done = 1'b0;
         check(bus.ack == '0, "spurious_done_ack", 32'(bus.ack), 32'h0);
         check(bus.down_valid == 1'b1, "spurious_done_state", 32'(bus.down_valid), 32'h1);
      end
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         check(bus.down_valid == 1'b1, "backpressure_valid", 32'(bus.down_valid), 32'h1);
         check(bus.ack == '0, "ack_early_issue", 32'(bus.ack), 32'h0);
      end
      bus.down_ready = 1'b1;
      @(negedge clk);
      bus.down_ready = 1'b0;
      check(bus.down_valid == 1'b0, "accept_drops_valid", 32'(bus.down_valid), 32'h0);

      if (abort_rst) begin
         rst     = 1'b1;
         bus.req = '0;
         @(negedge clk);
         rst = 1'b0;
         void'(q_ack.pop_back());
         model_ptr = 0;
         check_all_zero("reset_in_wait");
         bus.down_done = 1'b1;
         @(negedge clk);
         bus.down_done = 1'b0;
         @(negedge clk);
         check(bus.ack == '0, "done_after_reset", 32'(bus.ack), 32'h0);
         check(bus.busy == 1'b0, "idle_after_reset", 32'(bus.busy), 32'h0);
         return;
      end

      for (int i = 0; i < ddly; i++) begin
         @(negedge clk);
         check(bus.ack == '0, "ack_early_wait", 32'(bus.ack), 32'h0);
      end
      bus.down_done = 1'b1;
      @(negedge clk);
      bus.down_done = 1'b0;
      bus.req       = '0;
      check(bus.ack == N'(1 << exp_id), "ack_latency", 32'(bus.ack), 32'(1 << exp_id));
      @(negedge clk);
      check(bus.busy == 1'b0, "idle_latency", 32'(bus.busy), 32'h0);
      check(bus.ack == '0, "ack_one_cycle", 32'(bus.ack), 32'h0);
      model_ptr = (exp_id + 1) % N;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      logic [N-1:0]    r;
      logic [N*KW-1:0] k;
      bus.req        = '0;
      bus.req_key    = '0;
      bus.down_ready = 1'b0;
      bus.down_done  = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("idle_no_req");

      // Single requester, minimum latency
      run_txn(4'b0001, 16'h0003, 0, 0, 1'b0, 1'b0, 1'b0);

      // All requesting: grants rotate
      for (int t = 0; t < 5; t++) begin
         run_txn(4'b1111, 16'h3210, 0, 0, 1'b0, 1'b0, 1'b0);
      end

      // Backpressure for five cycles
      run_txn(4'b1010, 16'h9C7E, 5, 2, 1'b0, 1'b0, 1'b0);

      // Key snapshot with requester 2 dropping its request
      run_txn(4'b0100, 16'h0A00, 1, 1, 1'b1, 1'b0, 1'b0);

      // Spurious done while offered
      run_txn(4'b0011, 16'h00B6, 2, 0, 1'b0, 1'b1, 1'b0);

      for (int t = 0; t < 30; t++) begin
         r = N'($urandom_range(1, (1 << N) - 1));
         k = (N*KW)'($urandom);
         run_txn(r, k, $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 1'b0);
      end

      // Reset in WAIT, then the next grant must start from requester 0
      run_txn(4'b0100, 16'h0D00, 0, 0, 1'b0, 1'b0, 1'b1);
      run_txn(4'b1111, 16'h4321, 0, 0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check(q_offer.size() == 0, "offers_drained", 32'(q_offer.size()), 32'h0);
      check(q_ack.size() == 0, "acks_drained", 32'(q_ack.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rr_key_arbiter.md
Name: rr_key_arbiter

Overview:
- Shares one downstream key-processing resource among N_REQ requesters.
- Each requester uses a req / req_key / ack handshake; ack is a one-cycle pulse that advances the requester's key.
- Grants are issued round-robin, one transaction at a time.
- All outputs are registered, so there is no combinational path from any req or req_key to any ack. This breaks the req→ack→req_key loop by construction.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- KEY_W, 4, key width in bits.
- ID_W, $clog2(N_REQ), requester index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester request level.
- req_key  in  N_REQ*KEY_W  packed keys; requester i occupies bits [i*KEY_W +: KEY_W].
- ack  out  N_REQ  one-cycle completion pulse per requester.
- down_valid  out  1  key offered to downstream.
- down_key  out  KEY_W  key snapshot of the granted requester.
- down_id  out  ID_W  index of the granted requester.
- down_ready  in  1  downstream accepts when down_valid && down_ready.
- down_done  in  1  downstream completion pulse for the accepted key.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE, rr_ptr=0.
  - ack, down_valid, down_key, down_id, busy all =0.
  - Applies mid-transaction too: the transaction is abandoned, no ack is issued, and downstream sees down_valid drop.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is set, pick a winner: the first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Register down_id=winner and down_key=req_key[winner]; go to ISSUE with down_valid=1.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - Hold down_valid, down_key and down_id stable.
  - On down_valid && down_ready: down_valid←0, go to WAIT.
  - down_done in ISSUE is ignored.
- WAIT:
  - On down_done: ack[down_id]←1, go to ACK.
  - Any number of cycles may elapse; there is no timeout.
- ACK:
  - ack is high for exactly this one cycle.
  - Next: ack←0, rr_ptr←(down_id+1) mod N_REQ, go to IDLE.
- Minimum latency: req sampled at edge E0 → down_valid high after E0 → accepted at E1 (down_ready=1) → down_done in the cycle after E1 → ack high after E2 → IDLE after E3. Next grant possible at E4, so peak throughput is 1 transaction per 4 cycles.
- Key snapshot: down_key is captured at grant. Later changes on req_key do not affect the transaction.
- Requester drops req after grant: the transaction still completes and ack is still pulsed.
- Requests arriving in ISSUE/WAIT/ACK are not granted until IDLE.
- Fairness: a continuously requesting requester waits for at most N_REQ-1 other grants.
- Wrap-around: rr_ptr goes from N_REQ-1 to 0.
- ack is never high on more than one bit.
- busy = (state != IDLE).

Decomposition:
- arb_pkg holds the state enum typedef (IDLE, ISSUE, WAIT, ACK) and the N_REQ_MAX=16 constant.
- One natural sub-module, rr_pick: purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: any_req and winner index.
  - Implementation: rotate, priority-encode, un-rotate.
- FSM, snapshot registers and ack generation live in rr_key_arbiter.

Test Plan:
- Single requester: req=4'b0001, req_key[0]=4'h3, down_ready=1, down_done one cycle after accept → down_key=3, down_id=0, ack=4'b0001 for one cycle at E2, busy low from E3.
- Round-robin: req=4'b1111 held, keys 0,1,2,3, done on every transaction → down_id sequence 0,1,2,3,0; ack pulses rotate the same way.
- Backpressure: down_ready=0 for 5 cycles → down_valid, down_key, down_id stable throughout; acceptance on the first cycle down_ready=1; no ack before down_done.
- Key snapshot and req drop: after grant to requester 2 with key 4'hA, change req_key[2] to 4'h5 and drop req[2] → down_key stays 4'hA and ack[2] still pulses.
- Reset in WAIT: assert rst for one cycle → next cycle all outputs 0, state IDLE; a later down_done produces no ack; next grant starts from requester 0.
- Spurious down_done in ISSUE is ignored: no ack, state stays ISSUE until down_ready.
